// File: rtl/serial_fas_ctrl.sv
// Bit-serial adder/subtractor: one fas cell, LSB first, carry/borrow held in a flop between bits.
// Optional signed-overflow flag built only when SERIAL_FAS_OVF_EN is defined.

module fas (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);

    logic a_eff;

    // Subtract inverts a, so cout becomes the borrow of a - b - cin.
    assign a_eff = ~(a ^ a_ns);
    assign s     = a ^ b ^ cin;
    assign cout  = (a_eff & b) | (a_eff & cin) | (b & cin);

endmodule

module serial_fas_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_ns,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, r_sr_q;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             mode_q;
    logic             cout_q;
    logic             last_bit;
    logic             fas_s, fas_cout;

    fas u_fas (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .a_ns (mode_q),
        .s    (fas_s),
        .cout (fas_cout)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            r_sr_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_sr_q  <= op_a;
                        b_sr_q  <= op_b;
                        mode_q  <= a_ns;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                StRun: begin
                    r_sr_q  <= {fas_s, r_sr_q[WIDTH-1:1]};
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    carry_q <= fas_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    // Publish only on the final bit so outputs hold while the next op runs.
                    if (last_bit) begin
                        result_q <= {fas_s, r_sr_q[WIDTH-1:1]};
                        cout_q   <= fas_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

`ifdef SERIAL_FAS_OVF_EN
    logic msb_a_q, msb_b_q, ovf_q;
    logic signs_match;

    // Overflow needs like signs for add, unlike signs for subtract.
    assign signs_match = mode_q ? (msb_a_q == msb_b_q) : (msb_a_q != msb_b_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            msb_a_q <= 1'b0;
            msb_b_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == StIdle && start) begin
            msb_a_q <= op_a[WIDTH-1];
            msb_b_q <= op_b[WIDTH-1];
        end else if (state_q == StRun && last_bit) begin
            ovf_q <= signs_match && (fas_s != msb_a_q);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/serial_fas_ctrl.md
# serial_fas_ctrl

Bit-serial adder/subtractor controller built around a single `fas` full adder/subtractor cell. It accepts two WIDTH-bit operands and a mode bit. It feeds the `fas` cell one bit pair per clock, LSB first, and holds the carry/borrow in a flop between bits. Each `fas` sum bit is captured into a result shift register. It sits directly upstream and downstream of the `fas` instance: it drives `a`, `b`, `cin` and `a_ns`, and consumes `s` and `cout`.

## Interface
- `WIDTH`, default 8: operand/result width in bits. Legal range is 2 to 32.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a_ns`  in  1  mode: 1 = add (A+B), 0 = subtract (A−B). Latched at start.
- `op_a`  in  WIDTH  operand A; latched at start.
- `op_b`  in  WIDTH  operand B; latched at start.
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  WIDTH  sum or difference; held until the next accepted start.
- `cout`  out  1  add: final carry out; subtract: final borrow out (1 = A<B unsigned).
- `ovf`  out  1  signed overflow; present only with SERIAL_FAS_OVF_EN (see Configuration).

## Operation
- Exactly one `fas` instance is used. Its connections are:
  - `a` = bit 0 of the A shift register
  - `b` = bit 0 of the B shift register
  - `cin` = carry flop
  - `a_ns` = latched mode
- Cell function:
  - sum = a⊕b⊕cin
  - add: cout = maj(a, b, cin)
  - subtract: cout = maj(~a, b, cin), i.e. the borrow of a−b−cin
- The carry/borrow flop is cleared to 0 at start in both modes.
- FSM states and transitions:
  - IDLE:
    - `busy`=0, `done`=0.
    - On `start`=1: latch `op_a`, `op_b` and `a_ns`; clear the carry flop and the bit counter; go to RUN.
  - RUN:
    - Each cycle, shift `fas.s` into the result register at bit WIDTH−1 while the register shifts right.
    - Load the carry flop from `fas.cout`, shift both operand registers right, and increment the counter.
    - After the cycle that processes bit WIDTH−1, go to DONE.
  - DONE:
    - `done`=1 for exactly one cycle.
    - `result`, `cout` and `ovf` are valid and then hold.
    - Go to IDLE.
- `start` is ignored in RUN and DONE; no queuing.
- Changes on `op_a`, `op_b` or `a_ns` after the start cycle have no effect.
- Arithmetic is modulo 2^WIDTH.
- `cout` is the carry flop value after bit WIDTH−1.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0, counter=0, carry flop=0.
- Latency, with `start` sampled at edge k:
  - `busy`=1 from after edge k through edge k+WIDTH.
  - `done`=1 in the cycle after edge k+WIDTH.
  - The earliest next start is sampled at edge k+WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles.
- The `rst` mid-operation takes priority over all else:
  - Return to IDLE, clear all outputs.
  - No `done` pulse for the aborted operation.
- If `start` and `rst` are asserted together, reset wins and the start is dropped.
- Combinational path: flop → `fas` → flop. The worst case is the `cout` path, 28 time units (XNOR 8 + NAND 10 + NAND 10). The clock period must be ≥ 40 time units; the bench uses 50.

## Configuration
- `SERIAL_FAS_OVF_EN` defined:
  - `ovf` is computed and registered at DONE; `ovf` reset value is 0.
  - add: `ovf` = (A[W−1]==B[W−1]) && (R[W−1]!=A[W−1])
  - subtract: `ovf` = (A[W−1]!=B[W−1]) && (R[W−1]!=A[W−1])
  - The MSBs of A and B are captured at start.
- `SERIAL_FAS_OVF_EN` undefined:
  - The `ovf` port still exists and is tied to 0.
  - No overflow logic or MSB capture flops are built.

## Test plan
All scenarios use WIDTH=8 and clock period 50.
- Add: 0x35+0x4A, a_ns=1 → `done` at k+9, `result`=0x7F, `cout`=0, `ovf`=0; `busy` high exactly 8 cycles.
- Add with carry out: 0xFF+0x01 → `result`=0x00, `cout`=1, `ovf`=0. Then 0x7F+0x01 → `result`=0x80, `ovf`=1 (with OVF_EN) or 0 (without).
- Subtract: 0x50−0x20, a_ns=0 → `result`=0x30, `cout`=0. Then 0x20−0x50 → `result`=0xD0, `cout`=1, `ovf`=0. Then 0x80−0x01 → `result`=0x7F, `ovf`=1 with OVF_EN.
- Start while busy: start 0x11+0x22, pulse `start` with 0xFF/0xFF at k+3 → single `done`, `result`=0x33. `op_a` changed mid-RUN has no effect.
- Reset mid-op: start 0xAA+0x55, assert `rst` at k+4 for 1 cycle → next cycle `busy`=0, `result`=0, `cout`=0, no `done`. A following 0x01+0x02 gives `result`=0x03.
- Back-to-back: start asserted continuously → operations accepted every 10 cycles. Each `done` pulse is 1 cycle wide, and `result` holds between pulses.
